pattern_sequencer_mc: RTL and testbench

Multi-channel successor to the single-channel note pattern sequencer. It walks a per-channel song header, then the order list, then the pattern notes, all held in one shared 16-bit synchronous ROM. Channels are time-multiplexed through a single fetch engine with round-robin arbitration. It adds order-list looping (repeat bit), global start/stop control and per-channel done flags, and it feeds NUM_CH downstream voice/envelope blocks.

---
 rtl/pattern_sequencer_mc_pkg.sv | 26 ++
 rtl/pattern_sequencer_mc_rr_arbiter.sv | 38 +++
 rtl/pattern_sequencer_mc.sv | 161 ++++++++++++++++
 tb/tb_pattern_sequencer_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_mc_pkg.sv
// pattern_seq_pkg: ROM word layout and state encodings shared by the pattern sequencer.
package pattern_seq_pkg;
    localparam int HDR_BASE      = 0;
    localparam int PTR_W         = 8;
    localparam int HDR_OBASE_LSB = 0;
    localparam int HDR_OLEN_LSB  = 8;
    localparam int HDR_OLEN_W    = 5;
    localparam int HDR_REP_BIT   = 13;
    localparam int ORD_PADDR_LSB = 0;
    localparam int ORD_PLEN_LSB  = 8;
    localparam int ORD_PLEN_W    = 8;
    localparam int PAT_PITCH_LSB = 0;
    localparam int PAT_PITCH_W   = 6;
    localparam int PAT_LEN_LSB   = 6;
    localparam int PAT_LEN_W     = 5;
    localparam int PAT_INST_LSB  = 11;
    localparam int PAT_INST_W    = 4;

    typedef enum logic [2:0] {
        E_IDLE, E_HDR_A, E_HDR_D, E_ORD_A, E_ORD_D, E_PAT_A, E_PAT_D, E_EMIT
    } eng_t;

    typedef enum logic [1:0] {
        C_INIT, C_IDLE_ORD, C_IDLE_PAT, C_STOPPED
    } cst_t;
endpackage

// File: rtl/pattern_sequencer_mc_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after the last granted index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(r_last) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant_idx     = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= IW'(N - 1);
        else if (i_advance && o_any)
            r_last <= o_grant_idx;
    end
endmodule

// File: rtl/pattern_sequencer_mc.sv
// pattern_sequencer_mc: multi-channel note sequencer sharing one synchronous-ROM fetch engine.
// Each grant walks header -> order entry -> pattern word as far as the channel's state requires.
module pattern_sequencer_mc
    import pattern_seq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ROM_AW  = 8,
    parameter int PITCH_W = PAT_PITCH_W,
    parameter int NLEN_W  = PAT_LEN_W,
    parameter int INST_W  = PAT_INST_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [NUM_CH-1:0]          i_note_stb,
    output logic [NUM_CH-1:0]          o_note_valid,
    output logic [NUM_CH*PITCH_W-1:0]  o_note_pitch,
    output logic [NUM_CH*NLEN_W-1:0]   o_note_len,
    output logic [NUM_CH*INST_W-1:0]   o_note_instrument,
    output logic [NUM_CH-1:0]          o_ch_done,
    output logic                       o_busy,
    output logic [ROM_AW-1:0]          o_rom_addr,
    input  logic [15:0]                i_rom_data
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    eng_t                             r_state;
    logic [CH_W-1:0]                  r_ch;
    logic [NUM_CH-1:0]                r_pend;
    logic [NUM_CH-1:0]                r_note_valid;
    logic [NUM_CH-1:0]                r_rep;
    cst_t                             r_cst   [NUM_CH];
    logic [PTR_W-1:0]                 r_obase [NUM_CH];
    logic [PTR_W-1:0]                 r_oaddr [NUM_CH];
    logic [PTR_W-1:0]                 r_paddr [NUM_CH];
    logic [HDR_OLEN_W-1:0]            r_olen  [NUM_CH];
    logic [HDR_OLEN_W-1:0]            r_ocnt  [NUM_CH];
    logic [ORD_PLEN_W-1:0]            r_plen  [NUM_CH];
    logic [ORD_PLEN_W-1:0]            r_pcnt  [NUM_CH];
    logic [NUM_CH-1:0][PITCH_W-1:0]   r_pitch;
    logic [NUM_CH-1:0][NLEN_W-1:0]    r_len;
    logic [NUM_CH-1:0][INST_W-1:0]    r_inst;
    logic [NUM_CH-1:0]                w_stopped;
    logic [NUM_CH-1:0]                w_grant;
    logic [CH_W-1:0]                  w_gidx;
    logic                             w_any;
    logic                             w_adv;
    logic [HDR_OLEN_W-1:0]            w_olen;
    logic [ORD_PLEN_W-1:0]            w_plen;

    always_comb
        for (int c = 0; c < NUM_CH; c++)
            w_stopped[c] = (r_cst[c] == C_STOPPED);

    assign w_adv  = (r_state == E_IDLE) && !i_start && !i_stop;
    assign w_olen = i_rom_data[HDR_OLEN_LSB +: HDR_OLEN_W];
    assign w_plen = i_rom_data[ORD_PLEN_LSB +: ORD_PLEN_W];

    rr_arbiter #(.N(NUM_CH), .IW(CH_W)) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (r_pend & ~w_stopped),
        .i_advance   (w_adv),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    always_comb
        o_rom_addr = (r_state == E_HDR_A) ? ROM_AW'(HDR_BASE) + ROM_AW'(r_ch) :
                     (r_state == E_ORD_A) ? ROM_AW'(r_oaddr[r_ch]) :
                     (r_state == E_PAT_A) ? ROM_AW'(r_paddr[r_ch]) : '0;

    // Start/stop abandon any in-flight fetch but leave the note registers untouched.
    always_ff @(posedge i_clk) begin
        r_note_valid <= '0;
        if (i_rst) begin
            r_state <= E_IDLE;
            r_ch    <= '0;
            r_pend  <= '0;
            r_rep   <= '0;
            r_pitch <= '0;
            r_len   <= '0;
            r_inst  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_cst[c]   <= C_INIT;
                r_obase[c] <= '0;
                r_oaddr[c] <= '0;
                r_paddr[c] <= '0;
                r_olen[c]  <= '0;
                r_ocnt[c]  <= '0;
                r_plen[c]  <= '0;
                r_pcnt[c]  <= '0;
            end
        end else if (i_start || i_stop) begin
            r_state <= E_IDLE;
            r_pend  <= '0;
            for (int c = 0; c < NUM_CH; c++)
                r_cst[c] <= i_stop ? C_STOPPED : C_INIT;
        end else begin
            r_pend <= (r_pend & ~(w_adv ? w_grant : '0)) | (i_note_stb & ~w_stopped);
            case (r_state)
                E_IDLE: if (w_any) begin
                    r_ch    <= w_gidx;
                    r_state <= (r_cst[w_gidx] == C_INIT)     ? E_HDR_A :
                               (r_cst[w_gidx] == C_IDLE_ORD) ? E_ORD_A : E_PAT_A;
                end
                E_HDR_A: r_state <= E_HDR_D;
                E_HDR_D: begin
                    r_obase[r_ch] <= i_rom_data[HDR_OBASE_LSB +: PTR_W];
                    r_oaddr[r_ch] <= i_rom_data[HDR_OBASE_LSB +: PTR_W];
                    r_olen[r_ch]  <= (w_olen == '0) ? HDR_OLEN_W'(1) : w_olen;
                    r_ocnt[r_ch]  <= HDR_OLEN_W'(1);
                    r_rep[r_ch]   <= i_rom_data[HDR_REP_BIT];
                    r_state       <= E_ORD_A;
                end
                E_ORD_A: r_state <= E_ORD_D;
                E_ORD_D: begin
                    r_paddr[r_ch] <= i_rom_data[ORD_PADDR_LSB +: PTR_W];
                    r_plen[r_ch]  <= (w_plen == '0) ? ORD_PLEN_W'(1) : w_plen;
                    r_pcnt[r_ch]  <= ORD_PLEN_W'(1);
                    r_state       <= E_PAT_A;
                end
                E_PAT_A: r_state <= E_PAT_D;
                E_PAT_D: begin
                    r_pitch[r_ch]      <= i_rom_data[PAT_PITCH_LSB +: PITCH_W];
                    r_len[r_ch]        <= i_rom_data[PAT_LEN_LSB +: NLEN_W];
                    r_inst[r_ch]       <= i_rom_data[PAT_INST_LSB +: INST_W];
                    r_note_valid[r_ch] <= 1'b1;
                    r_state            <= E_EMIT;
                end
                default: begin
                    if (r_pcnt[r_ch] < r_plen[r_ch]) begin
                        r_paddr[r_ch] <= r_paddr[r_ch] + 1'b1;
                        r_pcnt[r_ch]  <= r_pcnt[r_ch] + 1'b1;
                        r_cst[r_ch]   <= C_IDLE_PAT;
                    end else if (r_ocnt[r_ch] < r_olen[r_ch]) begin
                        r_oaddr[r_ch] <= r_oaddr[r_ch] + 1'b1;
                        r_ocnt[r_ch]  <= r_ocnt[r_ch] + 1'b1;
                        r_cst[r_ch]   <= C_IDLE_ORD;
                    end else if (r_rep[r_ch]) begin
                        r_oaddr[r_ch] <= r_obase[r_ch];
                        r_ocnt[r_ch]  <= HDR_OLEN_W'(1);
                        r_cst[r_ch]   <= C_IDLE_ORD;
                    end else begin
                        r_cst[r_ch]   <= C_STOPPED;
                    end
                    r_state <= E_IDLE;
                end
            endcase
        end
    end

    assign o_note_valid      = r_note_valid;
    assign o_note_pitch      = r_pitch;
    assign o_note_len        = r_len;
    assign o_note_instrument = r_inst;
    assign o_ch_done         = w_stopped;
    assign o_busy            = (r_state != E_IDLE);
endmodule

// File: tb/tb_pattern_sequencer_mc.sv
// tb_pattern_sequencer_mc: scoreboard bench; expected notes and due cycles are queued at strobe time.
module tb_pattern_sequencer_mc;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_start = 1'b0, i_stop = 1'b0;
    logic [3:0]  i_note_stb = '0;
    logic [3:0]  o_note_valid, o_ch_done;
    logic [23:0] o_note_pitch;
    logic [19:0] o_note_len;
    logic [15:0] o_note_instrument;
    logic        o_busy;
    logic [7:0]  o_rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] rom [256];
    int          cyc = 0;
    int          ncmp = 0, nfail = 0;
    int          nidx [4];

    typedef struct {
        int          tag;
        int          ch;
        int          due;
        logic [14:0] note;
    } exp_t;
    exp_t exp_q[$];

    pattern_sequencer_mc dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_stop            (i_stop),
        .i_note_stb        (i_note_stb),
        .o_note_valid      (o_note_valid),
        .o_note_pitch      (o_note_pitch),
        .o_note_len        (o_note_len),
        .o_note_instrument (o_note_instrument),
        .o_ch_done         (o_ch_done),
        .o_busy            (o_busy),
        .o_rom_addr        (o_rom_addr),
        .i_rom_data        (rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[o_rom_addr];

    function automatic logic [14:0] note_of(input int ch);
        if (ch < 0) return '0;
        return {o_note_instrument[ch*4 +: 4], o_note_len[ch*5 +: 5], o_note_pitch[ch*6 +: 6]};
    endfunction

    function automatic logic [15:0] pw(input int c, input int k);
        return rom[(64 + 16*c + k) & 255];
    endfunction

    task automatic push(input int tag, input int ch, input int due, input logic [15:0] w);
        exp_t e;
        e.tag = tag; e.ch = ch; e.due = due; e.note = w[14:0];
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [3:0] m, output int t);
        t = cyc;
        i_note_stb = m;
        @(negedge clk);
        i_note_stb = '0;
    endtask

    task automatic pulse(input logic s, input logic p);
        i_start = s; i_stop = p;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
    endtask

    task automatic wait_note(output int ch);
        ch = -1;
        for (int n = 0; n < 40 && ch < 0; n++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (o_note_valid[c]) ch = c;
        end
    endtask

    task automatic test_reset;
        ncmp++;
        if (o_note_valid !== 4'h0 || o_ch_done !== 4'h0 || o_busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_ctl: valid %h done %h busy %b, expected 0 0 0", o_note_valid, o_ch_done, o_busy);
        end
        ncmp++;
        if ({o_note_pitch, o_note_len, o_note_instrument} !== 60'h0) begin
            nfail++;
            $display("FAIL reset_notes: %h, expected 0", {o_note_pitch, o_note_len, o_note_instrument});
        end
        ncmp++;
        if (o_rom_addr !== 8'h0) begin
            nfail++;
            $display("FAIL reset_addr: %h, expected 0", o_rom_addr);
        end
    endtask

    task automatic test_single;
        int t, ch;
        exp_t e;
        rom[0] = 16'h2110; rom[8'h10] = 16'h0220; rom[8'h20] = 16'h190C; rom[8'h21] = 16'h1A14;
        for (int i = 0; i < 4; i++) begin
            strobe(4'b0001, t);
            push(10 + i, 0, t + ((i == 0) ? 8 : (i == 2) ? 6 : 4), rom[(i % 2 == 0) ? 8'h20 : 8'h21]);
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        ncmp++;
        if (o_ch_done !== 4'h0) begin
            nfail++;
            $display("FAIL single_done: %h, expected 0", o_ch_done);
        end
    endtask

    task automatic test_no_repeat;
        int t, ch, bad;
        exp_t e;
        rom[0] = 16'h0110;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            strobe(4'b0001, t);
            push(20 + i, 0, t + ((i == 0) ? 8 : 4), rom[(i == 0) ? 8'h20 : 8'h21]);
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        @(negedge clk);
        ncmp++;
        if (o_ch_done !== 4'b0001) begin
            nfail++;
            $display("FAIL norep_done: %h, expected 1", o_ch_done);
        end
        strobe(4'b0001, t);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_note_valid !== 4'h0 || o_rom_addr !== 8'h0) bad++;
        end
        ncmp++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL norep_quiet: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_contention;
        int t, ch;
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            rom[c] = 16'h2100 | 16'(16 + c);
            rom[16 + c] = 16'h0800 | 16'(64 + 16*c);
            for (int k = 0; k < 8; k++) rom[64 + 16*c + k] = 16'(((c + 1) << 11) | ((k + 1) << 6) | (c*10 + k));
            nidx[c] = 0;
        end
        pulse(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            strobe(4'(1 << c), t);
            push(30 + c, c, t + 8, pw(c, nidx[c])); nidx[c]++;
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        strobe(4'hF, t);
        for (int c = 0; c < 4; c++) begin
            push(40 + c, c, t + 4*(c + 1), pw(c, nidx[c])); nidx[c]++;
        end
        strobe(4'b0000, ch);
        strobe(4'b0000, ch);
        t = t;
        repeat (4) begin
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        // last grant was ch3, so ch0 comes first; after a lone ch0 grant, ch2 wins the next tie
        strobe(4'b0101, t);
        push(50, 0, t + 4, pw(0, nidx[0])); nidx[0]++;
        push(51, 2, t + 8, pw(2, nidx[2])); nidx[2]++;
        repeat (2) begin
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        strobe(4'b0001, t);
        push(52, 0, t + 4, pw(0, nidx[0])); nidx[0]++;
        wait_note(ch); e = exp_q.pop_front(); ncmp++;
        if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
            nfail++;
            $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
        end
        strobe(4'b0101, t);
        push(53, 2, t + 4, pw(2, nidx[2])); nidx[2]++;
        push(54, 0, t + 8, pw(0, nidx[0])); nidx[0]++;
        repeat (2) begin
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
    endtask

    task automatic test_zero_len;
        int t, ch, bad;
        exp_t e;
        rom[1] = 16'h0030; rom[2] = 16'h2030; rom[8'h30] = 16'h0050; rom[8'h50] = 16'h2A55;
        pulse(1'b1, 1'b0);
        strobe(4'b0010, t);
        push(60, 1, t + 8, rom[8'h50]);
        wait_note(ch); e = exp_q.pop_front(); ncmp++;
        if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
            nfail++;
            $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
        end
        @(negedge clk);
        strobe(4'b0010, t);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_note_valid !== 4'h0) bad++;
        end
        ncmp++;
        if (bad != 0 || o_ch_done !== 4'b0010) begin
            nfail++;
            $display("FAIL zero_stop: %0d valid cycles done %h, expected 0 cycles done 2", bad, o_ch_done);
        end
        for (int i = 0; i < 3; i++) begin
            strobe(4'b0100, t);
            push(61 + i, 2, t + ((i == 0) ? 8 : 6), rom[8'h50]);
            wait_note(ch); e = exp_q.pop_front(); ncmp++;
            if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
                nfail++;
                $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
            end
        end
        @(negedge clk);
        ncmp++;
        if (o_ch_done !== 4'b0010) begin
            nfail++;
            $display("FAIL zero_loop_done: %h, expected 2", o_ch_done);
        end
    endtask

    task automatic test_start_abort;
        int t, ch, bad;
        exp_t e;
        rom[1] = 16'h0031; rom[8'h31] = 16'h0258; rom[8'h58] = 16'h1234; rom[8'h59] = 16'h0987;
        pulse(1'b1, 1'b0);
        strobe(4'b0010, t);
        push(70, 1, t + 8, rom[8'h58]);
        wait_note(ch); e = exp_q.pop_front(); ncmp++;
        if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
            nfail++;
            $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
        end
        strobe(4'b0010, t);
        @(negedge clk);
        pulse(1'b1, 1'b0);
        bad = 0;
        repeat (10) begin
            if (o_note_valid !== 4'h0 || o_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        ncmp++;
        if (bad != 0 || note_of(1) !== rom[8'h58][14:0]) begin
            nfail++;
            $display("FAIL abort: %0d active cycles note %h, expected 0 cycles note %h", bad, note_of(1), rom[8'h58][14:0]);
        end
        strobe(4'b0010, t);
        push(71, 1, t + 8, rom[8'h58]);
        wait_note(ch); e = exp_q.pop_front(); ncmp++;
        if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
            nfail++;
            $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
        end
    endtask

    task automatic test_stop;
        int t, bad;
        pulse(1'b1, 1'b1);
        ncmp++;
        if (o_ch_done !== 4'hF) begin
            nfail++;
            $display("FAIL stop_done: %h, expected f", o_ch_done);
        end
        strobe(4'hF, t);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_note_valid !== 4'h0 || o_busy !== 1'b0) bad++;
        end
        ncmp++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL stop_quiet: %0d active cycles, expected 0", bad);
        end
        pulse(1'b1, 1'b0);
        ncmp++;
        if (o_ch_done !== 4'h0) begin
            nfail++;
            $display("FAIL restart_done: %h, expected 0", o_ch_done);
        end
    endtask

    task automatic test_reset_mid;
        int t, ch;
        exp_t e;
        strobe(4'b0001, t);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        ncmp++;
        if ({o_note_valid, o_note_pitch, o_note_len, o_note_instrument, o_ch_done, o_busy, o_rom_addr} !== 77'h0) begin
            nfail++;
            $display("FAIL reset_mid: %h, expected 0", {o_note_valid, o_note_pitch, o_note_len, o_note_instrument, o_ch_done, o_busy, o_rom_addr});
        end
        strobe(4'b0001, t);
        push(80, 0, t + 8, pw(0, 0));
        wait_note(ch); e = exp_q.pop_front(); ncmp++;
        if (ch !== e.ch || cyc !== e.due || note_of(ch) !== e.note) begin
            nfail++;
            $display("FAIL note%0d: got ch %0d cyc %0d note %h, expected ch %0d cyc %0d note %h", e.tag, ch, cyc, note_of(ch), e.ch, e.due, e.note);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        test_reset;
        test_single;
        test_no_repeat;
        test_contention;
        test_zero_len;
        test_start_abort;
        test_stop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
